// File: rtl/gnr_pkg.sv
// Shared definitions for the GRN-simulator node array: default node
// dimensions and the helper functions that size the slow-copy phase counter.
// Build option: NODE_CHG_CNT_EN (enables the s0 change counter in gnr_node_ratio).
package gnr_pkg;

  localparam int GNR_WIDTH_DEF = 1;
  localparam int GNR_RATIO_DEF = 2;
  localparam int GNR_CHG_W_DEF = 16;

  // Ceiling log2 that also works at elaboration time; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Phase counter width; RATIO=1 still needs one bit so the register exists.
  function automatic int gnr_ph_w(input int ratio);
    int w;
    w = clog2(ratio);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/gnr_phase_ctr.sv
// Phase counter for the slow state copy. Counts qualified start_s0 strobes
// and raises fire on the strobe that completes a group of RATIO strobes.
// The phase never exceeds RATIO-1, so the terminal compare is exact.
module gnr_phase_ctr
  import gnr_pkg::*;
#(
  parameter int RATIO = GNR_RATIO_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic adv,
  output logic fire
);

  localparam int PH_W = gnr_ph_w(RATIO);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(RATIO - 1);

  logic [PH_W-1:0] r_ph;

  assign fire = adv & (r_ph == PH_LAST);

  // Reset clears the phase; a node reload presets it so the very next strobe commits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ph <= '0;
    end else if (load) begin
      r_ph <= PH_LAST;
    end else if (adv) begin
      if (r_ph == PH_LAST) begin
        r_ph <= '0;
      end else begin
        r_ph <= r_ph + PH_W'(1);
      end
    end
  end

endmodule

// File: rtl/gnr_node_ratio.sv
// GRN-simulator node holding a WIDTH-bit state in a slow copy (s0, committed
// once every RATIO start_s0 strobes) and a fast copy (s1, committed on every
// start_s1 strobe). Both copies fan back into the network on node_s0/node_s1.
// Build option: NODE_CHG_CNT_EN adds a saturating count of s0 value changes;
// without it chg_cnt is tied low and no counter flops exist.
module gnr_node_ratio
  import gnr_pkg::*;
#(
  parameter int WIDTH = GNR_WIDTH_DEF,
  parameter int RATIO = GNR_RATIO_DEF,
  parameter int CHG_W = GNR_CHG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             reset_nos,
  input  logic             start_s0,
  input  logic             start_s1,
  input  logic [WIDTH-1:0] init_state,
  input  logic [WIDTH-1:0] next_s0,
  input  logic [WIDTH-1:0] next_s1,
  output logic [WIDTH-1:0] s0,
  output logic [WIDTH-1:0] s1,
  output logic [WIDTH-1:0] node_s0,
  output logic [WIDTH-1:0] node_s1,
  output logic             s0_upd,
  output logic             match,
  output logic [CHG_W-1:0] chg_cnt
);

  logic [WIDTH-1:0] r_s0;
  logic [WIDTH-1:0] r_s1;
  logic             r_s0_upd;
  logic             w_adv;
  logic             w_fire;
  logic             w_upd_s1;

  // A reload in the same cycle wins, so the strobe must not advance the phase.
  assign w_adv    = start & start_s0 & ~reset_nos;
  assign w_upd_s1 = start & start_s1;

  gnr_phase_ctr #(
    .RATIO(RATIO)
  ) u_phase (
    .clk (clk),
    .rst (rst),
    .load(reset_nos),
    .adv (w_adv),
    .fire(w_fire)
  );

  // State copies: reset, reload from init_state, or independent strobe commits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0     <= '0;
      r_s1     <= '0;
      r_s0_upd <= 1'b0;
    end else if (reset_nos) begin
      r_s0     <= init_state;
      r_s1     <= init_state;
      r_s0_upd <= 1'b0;
    end else begin
      if (w_fire) begin
        r_s0 <= next_s0;
      end
      if (w_upd_s1) begin
        r_s1 <= next_s1;
      end
      r_s0_upd <= w_fire;
    end
  end

`ifdef NODE_CHG_CNT_EN
  logic [CHG_W-1:0] r_chg_cnt;

  // Count slow-copy commits that actually change the value, holding at all-ones.
  always_ff @(posedge clk) begin
    if (rst || reset_nos) begin
      r_chg_cnt <= '0;
    end else if (w_fire && (next_s0 != r_s0) && (r_chg_cnt != {CHG_W{1'b1}})) begin
      r_chg_cnt <= r_chg_cnt + CHG_W'(1);
    end
  end

  assign chg_cnt = r_chg_cnt;
`else
  assign chg_cnt = '0;
`endif

  assign s0      = r_s0;
  assign s1      = r_s1;
  assign node_s0 = r_s0;
  assign node_s1 = r_s1;
  assign s0_upd  = r_s0_upd;
  assign match   = (r_s0 == r_s1);

endmodule

// File: tb/tb_gnr_node_ratio.sv
// Directed bench for gnr_node_ratio: a vector table run against a RATIO=2
// node, plus hand-written sequences on RATIO=3 and RATIO=1 nodes that share
// the same stimulus. Change-counter expectations follow NODE_CHG_CNT_EN.
module tb_gnr_node_ratio;

  localparam int W  = 2;
  localparam int CW = 2;

  typedef struct {
    logic         rst;
    logic         start;
    logic         rnos;
    logic         st0;
    logic         st1;
    logic [W-1:0] init;
    logic [W-1:0] n0;
    logic [W-1:0] n1;
    logic [W-1:0] eS0;
    logic [W-1:0] eS1;
    logic         eUpd;
    logic         eMatch;
    logic [CW-1:0] eCnt;
  } vec_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic          resetNos;
  logic          startS0;
  logic          startS1;
  logic [W-1:0]  initState;
  logic [W-1:0]  nextS0;
  logic [W-1:0]  nextS1;

  logic [W-1:0]  s0R2, s1R2, nodeS0R2, nodeS1R2;
  logic          updR2, matchR2;
  logic [CW-1:0] cntR2;
  logic [W-1:0]  s0R3, s1R3, nodeS0R3, nodeS1R3;
  logic          updR3, matchR3;
  logic [CW-1:0] cntR3;
  logic [W-1:0]  s0R1, s1R1, nodeS0R1, nodeS1R1;
  logic          updR1, matchR1;
  logic [CW-1:0] cntR1;

  int checks = 0;
  int errors = 0;

  gnr_node_ratio #(.WIDTH(W), .RATIO(2), .CHG_W(CW)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .reset_nos(resetNos),
    .start_s0(startS0), .start_s1(startS1), .init_state(initState),
    .next_s0(nextS0), .next_s1(nextS1), .s0(s0R2), .s1(s1R2),
    .node_s0(nodeS0R2), .node_s1(nodeS1R2), .s0_upd(updR2),
    .match(matchR2), .chg_cnt(cntR2)
  );

  gnr_node_ratio #(.WIDTH(W), .RATIO(3), .CHG_W(CW)) u_dut3 (
    .clk(clk), .rst(rst), .start(start), .reset_nos(resetNos),
    .start_s0(startS0), .start_s1(startS1), .init_state(initState),
    .next_s0(nextS0), .next_s1(nextS1), .s0(s0R3), .s1(s1R3),
    .node_s0(nodeS0R3), .node_s1(nodeS1R3), .s0_upd(updR3),
    .match(matchR3), .chg_cnt(cntR3)
  );

  gnr_node_ratio #(.WIDTH(W), .RATIO(1), .CHG_W(CW)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .reset_nos(resetNos),
    .start_s0(startS0), .start_s1(startS1), .init_state(initState),
    .next_s0(nextS0), .next_s1(nextS1), .s0(s0R1), .s1(s1R1),
    .node_s0(nodeS0R1), .node_s1(nodeS1R1), .s0_upd(updR1),
    .match(matchR1), .chg_cnt(cntR1)
  );

  // Free-running clock, rising edge at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input int r, input int st, input int rn, input int a0, input int a1,
                              input int ini, input int x0, input int x1,
                              input int es0, input int es1, input int eu, input int em, input int ec);
    vec_t v;
    v.rst    = r[0];
    v.start  = st[0];
    v.rnos   = rn[0];
    v.st0    = a0[0];
    v.st1    = a1[0];
    v.init   = ini[W-1:0];
    v.n0     = x0[W-1:0];
    v.n1     = x1[W-1:0];
    v.eS0    = es0[W-1:0];
    v.eS1    = es1[W-1:0];
    v.eUpd   = eu[0];
    v.eMatch = em[0];
    v.eCnt   = ec[CW-1:0];
    return v;
  endfunction

  task automatic checkVal(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s[%0d] got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then sample 1 ns after the rising edge.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst       = v.rst;
    start     = v.start;
    resetNos  = v.rnos;
    startS0   = v.st0;
    startS1   = v.st1;
    initState = v.init;
    nextS0    = v.n0;
    nextS1    = v.n1;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    logic [CW-1:0] expCnt;
`ifdef NODE_CHG_CNT_EN
    expCnt = v.eCnt;
`else
    expCnt = '0;
`endif
    checkVal("s0", idx, 32'(s0R2), 32'(v.eS0));
    checkVal("s1", idx, 32'(s1R2), 32'(v.eS1));
    checkVal("node_s0", idx, 32'(nodeS0R2), 32'(v.eS0));
    checkVal("node_s1", idx, 32'(nodeS1R2), 32'(v.eS1));
    checkVal("s0_upd", idx, 32'(updR2), 32'(v.eUpd));
    checkVal("match", idx, 32'(matchR2), 32'(v.eMatch));
    checkVal("chg_cnt", idx, 32'(cntR2), 32'(expCnt));
  endtask

  vec_t vecs[26];
  logic [W-1:0] r3Next[6];
  logic [W-1:0] r3ExpS0[6];
  logic         r3ExpUpd[6];

  initial begin
    rst = 1'b1; start = 1'b0; resetNos = 1'b0; startS0 = 1'b0; startS1 = 1'b0;
    initState = '0; nextS0 = '0; nextS1 = '0;

    //               rst st rn s0 s1 ini n0 n1  eS0 eS1 upd mat cnt
    vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0);
    vecs[1]  = mk(0, 1, 0, 1, 0, 0, 1, 0,  0, 0, 0, 1, 0);
    vecs[2]  = mk(0, 1, 0, 1, 0, 0, 1, 0,  1, 0, 1, 0, 1);
    vecs[3]  = mk(0, 1, 0, 1, 0, 0, 1, 0,  1, 0, 0, 0, 1);
    vecs[4]  = mk(0, 1, 1, 0, 0, 3, 1, 0,  3, 3, 0, 1, 0);
    vecs[5]  = mk(0, 1, 0, 1, 0, 3, 1, 0,  1, 3, 1, 0, 1);
    vecs[6]  = mk(0, 1, 0, 1, 1, 0, 1, 1,  1, 1, 0, 1, 1);
    vecs[7]  = mk(0, 1, 0, 1, 0, 0, 1, 1,  1, 1, 1, 1, 1);
    for (int i = 8; i <= 12; i++) begin
      vecs[i] = mk(0, 0, 0, 1, 1, 0, 2, 2,  1, 1, 0, 1, 1);
    end
    vecs[13] = mk(0, 1, 0, 1, 0, 0, 2, 2,  1, 1, 0, 1, 1);
    vecs[14] = mk(0, 1, 0, 1, 0, 0, 2, 2,  2, 1, 1, 0, 2);
    vecs[15] = mk(0, 1, 1, 1, 1, 2, 3, 3,  2, 2, 0, 1, 0);
    vecs[16] = mk(0, 1, 0, 1, 0, 2, 3, 3,  3, 2, 1, 0, 1);
    vecs[17] = mk(0, 0, 1, 0, 0, 1, 3, 3,  1, 1, 0, 1, 0);
    vecs[18] = mk(0, 1, 0, 1, 0, 1, 2, 0,  2, 1, 1, 0, 1);
    vecs[19] = mk(0, 1, 0, 1, 0, 1, 3, 0,  2, 1, 0, 0, 1);
    vecs[20] = mk(0, 1, 0, 1, 0, 1, 3, 0,  3, 1, 1, 0, 2);
    vecs[21] = mk(0, 1, 0, 1, 0, 1, 0, 0,  3, 1, 0, 0, 2);
    vecs[22] = mk(0, 1, 0, 1, 0, 1, 0, 0,  0, 1, 1, 0, 3);
    vecs[23] = mk(0, 1, 0, 1, 0, 1, 1, 0,  0, 1, 0, 0, 3);
    vecs[24] = mk(0, 1, 0, 1, 0, 1, 1, 0,  1, 1, 1, 1, 3);
    vecs[25] = mk(1, 1, 1, 1, 1, 3, 3, 3,  0, 0, 0, 1, 0);

    r3Next   = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2};
    r3ExpS0  = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};
    r3ExpUpd = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    for (int i = 0; i < 26; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(i, vecs[i]);
    end

    // RATIO=3: reload arms the phase, then commits land on strobes 1 and 4 only.
    applyStimulus(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    checkVal("r3_reload_s0", 0, 32'(s0R3), 32'd0);
    checkVal("r3_reload_upd", 0, 32'(updR3), 32'd0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(mk(0, 1, 0, 1, 0, 0, int'(r3Next[i]), 0, 0, 0, 0, 0, 0));
      checkVal("r3_s0", i, 32'(s0R3), 32'(r3ExpS0[i]));
      checkVal("r3_upd", i, 32'(updR3), 32'(r3ExpUpd[i]));
    end

    // RATIO=1: every strobe commits and back-to-back commits hold s0_upd high.
    applyStimulus(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    checkVal("r1_reload_upd", 0, 32'(updR1), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(mk(0, 1, 0, 1, 0, 0, i, 0, 0, 0, 0, 0, 0));
      checkVal("r1_s0", i, 32'(s0R1), 32'(i));
      checkVal("r1_upd", i, 32'(updR1), 32'd1);
    end
    applyStimulus(mk(0, 1, 0, 0, 1, 0, 0, 3, 0, 0, 0, 0, 0));
    checkVal("r1_idle_upd", 0, 32'(updR1), 32'd0);
    checkVal("r1_idle_s0", 0, 32'(s0R1), 32'd3);
    checkVal("r1_match", 0, 32'(matchR1), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
